lbp_img_server: RTL

//  Responder at the far end of the gray/lbp interface of the LBP engine. Holds one
//  IMG_W x IMG_H 8-bit gray image, preloaded over a streaming port, and answers the

---
 rtl/lbp_img_server.sv | 122 ++++++++++++
 1 files changed

// File: rtl/lbp_img_server.sv
// Image/result memory server for the LBP engine: preloads a gray image, answers
// zero-latency pixel reads, captures LBP codes and streams them out with a zeroed border.
module lbp_img_server #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          img_valid,
  input  logic [DW-1:0] img_data,
  input  logic [AW-1:0] gray_addr,
  input  logic          gray_req,
  output logic          gray_ready,
  output logic [DW-1:0] gray_data,
  input  logic [AW-1:0] lbp_addr,
  input  logic          lbp_valid,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          done,
  output logic          proto_err
);

  localparam int              NPIX     = IMG_W * IMG_H;
  localparam int              CW       = $clog2(IMG_W);
  localparam int              RW       = AW - CW;
  localparam logic [AW-1:0]   LAST     = AW'(NPIX - 1);
  localparam logic [AW:0]     NPIX_X   = (AW+1)'(NPIX);
  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SERVE, DUMP, DONE} state_t;

  state_t        state;
  logic [AW-1:0] load_cnt;
  logic [AW-1:0] dump_cnt;
  logic [DW-1:0] img_mem [NPIX];
  logic [DW-1:0] res_mem [NPIX];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NPIX_X;
  endfunction

  function automatic logic is_border(input logic [AW-1:0] a);
    return (a[CW-1:0] == '0) || (a[CW-1:0] == COL_LAST) ||
           (a[AW-1:CW] == '0) || (a[AW-1:CW] == ROW_LAST);
  endfunction

  logic img_we, res_we, lbp_bad, gray_bad;

  always_comb begin
    img_we   = img_valid && (state == IDLE || state == LOAD);
    lbp_bad  = lbp_valid && (state != SERVE || !in_range(lbp_addr) || is_border(lbp_addr));
    res_we   = lbp_valid && !lbp_bad;
    gray_bad = (state == SERVE) && gray_req && !in_range(gray_addr);
  end

  // NOTE: the RAMs sit in their own reset-less block; resetting an array would turn it into flops.
  always_ff @(posedge clk) begin
    if (img_we) img_mem[load_cnt] <= img_data;
    if (res_we) res_mem[lbp_addr] <= lbp_data;
  end

  // Reads are asynchronous: the engine samples gray_data on the edge after it drives gray_addr.
  always_comb begin
    gray_data = '0;
    if (state == SERVE && gray_req && in_range(gray_addr)) gray_data = img_mem[gray_addr];
    out_data = '0;
    if (state == DUMP && !is_border(dump_cnt)) out_data = res_mem[dump_cnt];
  end

  assign out_addr = dump_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      load_cnt   <= '0;
      dump_cnt   <= '0;
      gray_ready <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (img_valid) begin
          load_cnt <= load_cnt + 1'b1;
          state    <= LOAD;
        end
        LOAD: if (img_valid) begin
          load_cnt <= load_cnt + 1'b1;
          if (load_cnt == LAST) begin
            state      <= SERVE;
            gray_ready <= 1'b1;
          end
        end
        SERVE: if (finish) begin
          state      <= DUMP;
          gray_ready <= 1'b0;
          out_valid  <= 1'b1;
          dump_cnt   <= '0;
        end
        DUMP: if (out_ready) begin
          if (dump_cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else begin
            dump_cnt <= dump_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (lbp_bad || gray_bad) proto_err <= 1'b1;
    end
  end

endmodule
